regfile_wb_ctrl: RTL and testbench

REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

---
 rtl/regfile_wb_ctrl_if.sv | 36 +++
 rtl/regfile_wb_ctrl.sv | 118 +++++++++++
 tb/tb_regfile_wb_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_ctrl_if.sv
// Writeback/issue/decode bundle between the requesters, the decoder and regfile_wb_ctrl.
// The master side drives requests and source indices; the slave side is the controller.
interface regfile_wb_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
);
    logic              AluReq;
    logic [IDX_W-1:0]  AluRD;
    logic [DATA_W-1:0] AluData;
    logic              AluGnt;
    logic              MemReq;
    logic [IDX_W-1:0]  MemRD;
    logic [DATA_W-1:0] MemData;
    logic              MemGnt;
    logic              IssueVld;
    logic [IDX_W-1:0]  IssueRD;
    logic [IDX_W-1:0]  RS1;
    logic [IDX_W-1:0]  RS2;
    logic              Hazard;
    logic [IDX_W-1:0]  RD;
    logic [DATA_W-1:0] WData;
    logic              RegWr;
    logic              BusyErr;

    modport master (
        output AluReq, AluRD, AluData, MemReq, MemRD, MemData,
        output IssueVld, IssueRD, RS1, RS2,
        input  AluGnt, MemGnt, Hazard, RD, WData, RegWr, BusyErr
    );

    modport slave (
        input  AluReq, AluRD, AluData, MemReq, MemRD, MemData,
        input  IssueVld, IssueRD, RS1, RS2,
        output AluGnt, MemGnt, Hazard, RD, WData, RegWr, BusyErr
    );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback arbiter with busy scoreboard and hazard detection.
// Define WB_RR_ARB_EN for round-robin arbitration; otherwise Mem has fixed priority over ALU.
module regfile_wb_ctrl #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    regfile_wb_ctrl_if.slave  bus
);
    localparam int NREG = 1 << IDX_W;

    logic              alu_gnt;
    logic              mem_gnt;

    logic              wb_vld_p0;
    logic [IDX_W-1:0]  wb_rd_p0;
    logic [DATA_W-1:0] wb_data_p0;

    logic              vld_p1;
    logic [IDX_W-1:0]  rd_p1;
    logic [DATA_W-1:0] wdata_p1;

    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic [NREG-1:0]   set_mask;
    logic [NREG-1:0]   clr_mask;
    logic              busy_err_q;
    logic              busy_err_d;

`ifdef WB_RR_ARB_EN
    typedef enum logic {PTR_MEM, PTR_ALU} ptr_t;
    ptr_t ptr_q;
    ptr_t ptr_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ptr_q <= PTR_MEM;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // The pointer names the side that wins a tie; it flips to the other side after each grant.
    always_comb begin
        alu_gnt = 1'b0;
        mem_gnt = 1'b0;
        ptr_d   = ptr_q;
        if (!Reset) begin
            if (bus.MemReq && (!bus.AluReq || ptr_q == PTR_MEM)) begin
                mem_gnt = 1'b1;
                ptr_d   = PTR_ALU;
            end else if (bus.AluReq) begin
                alu_gnt = 1'b1;
                ptr_d   = PTR_MEM;
            end
        end
    end
`else
    always_comb begin
        alu_gnt = 1'b0;
        mem_gnt = 1'b0;
        if (!Reset) begin
            mem_gnt = bus.MemReq;
            alu_gnt = bus.AluReq && !bus.MemReq;
        end
    end
`endif

    // Stage p0: select the granted writeback
    always_comb begin
        wb_vld_p0  = mem_gnt || alu_gnt;
        wb_rd_p0   = mem_gnt ? bus.MemRD   : bus.AluRD;
        wb_data_p0 = mem_gnt ? bus.MemData : bus.AluData;
    end

    // Stage p1: registered register-file write port
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vld_p1   <= 1'b0;
            rd_p1    <= '0;
            wdata_p1 <= '0;
        end else begin
            vld_p1 <= wb_vld_p0 && (wb_rd_p0 != '0);
            if (wb_vld_p0) begin
                rd_p1    <= wb_rd_p0;
                wdata_p1 <= wb_data_p0;
            end
        end
    end

    // A set in the same cycle as the commit of that register overrides the clear.
    always_comb begin
        set_mask   = (bus.IssueVld && bus.IssueRD != '0) ? (NREG'(1) << bus.IssueRD) : '0;
        clr_mask   = vld_p1 ? (NREG'(1) << rd_p1) : '0;
        busy_d     = ((busy_q & ~clr_mask) | set_mask) & ~NREG'(1);
        busy_err_d = busy_err_q || (|(busy_q & ~clr_mask & set_mask));
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy_q     <= '0;
            busy_err_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            busy_err_q <= busy_err_d;
        end
    end

    assign bus.AluGnt  = alu_gnt;
    assign bus.MemGnt  = mem_gnt;
    assign bus.Hazard  = !Reset && (((bus.RS1 != '0) && busy_q[bus.RS1]) ||
                                    ((bus.RS2 != '0) && busy_q[bus.RS2]));
    assign bus.RD      = rd_p1;
    assign bus.WData   = wdata_p1;
    assign bus.RegWr   = vld_p1;
    assign bus.BusyErr = busy_err_q;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: vector table, directed corner sequences and
// randomized traffic against a scoreboard model. Honours WB_RR_ARB_EN like the design.
module tb_regfile_wb_ctrl;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    regfile_wb_ctrl_if bus ();

    regfile_wb_ctrl dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        alu_req;
        logic [4:0]  alu_rd;
        logic [31:0] alu_data;
        logic        mem_req;
        logic [4:0]  mem_rd;
        logic [31:0] mem_data;
        logic        iss_vld;
        logic [4:0]  iss_rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        e_alu_gnt;
        logic        e_mem_gnt;
        logic        e_hazard;
        logic        e_regwr;
        logic [4:0]  e_rd;
        logic [31:0] e_wdata;
    } vec_t;

    localparam int NV = 9;
    localparam logic [31:0] DA = 32'hA5A5_0001;
    localparam logic [31:0] DB = 32'h5A5A_0002;
    localparam logic [31:0] DC = 32'hC0DE_0003;
    localparam logic [31:0] DF = 32'hFFFF_FFFF;
    vec_t vt [NV];

    // Reference model state: scoreboard of busy registers, pending write port, requesters
    bit          m_busy [32];
    bit          m_regwr;
    logic [4:0]  m_rd;
    logic [31:0] m_wdata;
    bit          m_err;
    bit          m_last_mem;
    bit          ap, mp, iv, g_alu, g_mem, e_haz, e_mem;
    logic [4:0]  ard, mrd, ird, r1, r2, nrd;
    logic [31:0] adat, mdat, ndat;
    int          clearing;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.AluReq   = 1'b0;
        bus.AluRD    = '0;
        bus.AluData  = '0;
        bus.MemReq   = 1'b0;
        bus.MemRD    = '0;
        bus.MemData  = '0;
        bus.IssueVld = 1'b0;
        bus.IssueRD  = '0;
        bus.RS1      = '0;
        bus.RS2      = '0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        idle();
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_regwr    = 1'b0;
        m_rd       = '0;
        m_wdata    = '0;
        m_err      = 1'b0;
        m_last_mem = 1'b0;
        ap         = 1'b0;
        mp         = 1'b0;
    endtask

    initial begin
        idle();
        vt[0] = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,5'd10, 5'd10,5'd0,  1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0};
        vt[1] = '{1'b0,5'd0,32'h0, 1'b1,5'd10,DA,   1'b0,5'd0,  5'd10,5'd0,  1'b0,1'b1,1'b1, 1'b1,5'd10,DA};
        vt[2] = '{1'b1,5'd11,DB,   1'b0,5'd0,32'h0, 1'b0,5'd0,  5'd0,5'd10,  1'b1,1'b0,1'b1, 1'b1,5'd11,DB};
        vt[3] = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,5'd12, 5'd10,5'd0,  1'b0,1'b0,1'b0, 1'b0,5'd11,DB};
        vt[4] = '{1'b1,5'd0,DF,    1'b0,5'd0,32'h0, 1'b0,5'd0,  5'd12,5'd10, 1'b1,1'b0,1'b1, 1'b0,5'd0,DF};
        vt[5] = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,5'd0,  5'd12,5'd0,  1'b0,1'b0,1'b1, 1'b0,5'd0,DF};
        vt[6] = '{1'b0,5'd0,32'h0, 1'b1,5'd12,DC,   1'b0,5'd0,  5'd0,5'd0,   1'b0,1'b1,1'b0, 1'b1,5'd12,DC};
        vt[7] = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0,  5'd12,5'd0,  1'b0,1'b0,1'b1, 1'b0,5'd12,DC};
        vt[8] = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0,  5'd12,5'd12, 1'b0,1'b0,1'b0, 1'b0,5'd12,DC};

        // Reset state with requests pending: no grants, all outputs cleared
        bus.AluReq = 1'b1;
        bus.MemReq = 1'b1;
        bus.RS1    = 5'd5;
        repeat (2) @(negedge Clk);
        #2;
        chk1 ("rst_alu_gnt", bus.AluGnt, 1'b0);
        chk1 ("rst_mem_gnt", bus.MemGnt, 1'b0);
        chk1 ("rst_hazard",  bus.Hazard, 1'b0);
        chk1 ("rst_regwr",   bus.RegWr, 1'b0);
        chk32("rst_rd",      32'(bus.RD), 32'h0);
        chk32("rst_wdata",   bus.WData, 32'h0);
        chk1 ("rst_busyerr", bus.BusyErr, 1'b0);

        // Vector table: comb outputs checked in-cycle, registered ones one cycle later
        do_reset();
        for (int i = 0; i <= NV; i++) begin
            @(negedge Clk);
            if (i < NV) begin
                bus.AluReq   = vt[i].alu_req;
                bus.AluRD    = vt[i].alu_rd;
                bus.AluData  = vt[i].alu_data;
                bus.MemReq   = vt[i].mem_req;
                bus.MemRD    = vt[i].mem_rd;
                bus.MemData  = vt[i].mem_data;
                bus.IssueVld = vt[i].iss_vld;
                bus.IssueRD  = vt[i].iss_rd;
                bus.RS1      = vt[i].rs1;
                bus.RS2      = vt[i].rs2;
            end else begin
                idle();
            end
            #2;
            if (i < NV) begin
                chk1("vec_alu_gnt", bus.AluGnt, vt[i].e_alu_gnt);
                chk1("vec_mem_gnt", bus.MemGnt, vt[i].e_mem_gnt);
                chk1("vec_hazard",  bus.Hazard, vt[i].e_hazard);
            end
            if (i > 0) begin
                chk1 ("vec_regwr", bus.RegWr, vt[i-1].e_regwr);
                chk32("vec_rd",    32'(bus.RD), 32'(vt[i-1].e_rd));
                chk32("vec_wdata", bus.WData, vt[i-1].e_wdata);
            end
            chk1("vec_busyerr", bus.BusyErr, 1'b0);
        end

        // Issue -> hazard -> ALU writeback -> commit -> hazard cleared
        do_reset();
        @(negedge Clk);
        bus.IssueVld = 1'b1;
        bus.IssueRD  = 5'd5;
        @(negedge Clk);
        bus.IssueVld = 1'b0;
        bus.RS1      = 5'd5;
        bus.AluReq   = 1'b1;
        bus.AluRD    = 5'd5;
        bus.AluData  = 32'h1234_5678;
        #2;
        chk1("seq1_hazard", bus.Hazard, 1'b1);
        chk1("seq1_alu_gnt", bus.AluGnt, 1'b1);
        @(negedge Clk);
        bus.AluReq = 1'b0;
        #2;
        chk1 ("seq1_regwr", bus.RegWr, 1'b1);
        chk32("seq1_rd", 32'(bus.RD), 32'd5);
        chk32("seq1_wdata", bus.WData, 32'h1234_5678);
        chk1 ("seq1_hazard_commit", bus.Hazard, 1'b1);
        @(negedge Clk);
        #2;
        chk1("seq1_hazard_clear", bus.Hazard, 1'b0);
        chk1("seq1_regwr_off", bus.RegWr, 1'b0);

        // Both requesters held for four cycles
        do_reset();
        for (int k = 0; k <= 4; k++) begin
            @(negedge Clk);
            if (k < 4) begin
                bus.AluReq  = 1'b1;
                bus.AluRD   = 5'd3;
                bus.AluData = 32'hAAAA_0003;
                bus.MemReq  = 1'b1;
                bus.MemRD   = 5'd4;
                bus.MemData = 32'hBBBB_0004;
            end else begin
                idle();
            end
            #2;
            if (k > 0) begin
                chk1 ("arb_regwr", bus.RegWr, 1'b1);
                chk32("arb_rd", 32'(bus.RD), e_mem ? 32'd4 : 32'd3);
                chk32("arb_wdata", bus.WData, e_mem ? 32'hBBBB_0004 : 32'hAAAA_0003);
            end
            if (k < 4) begin
`ifdef WB_RR_ARB_EN
                e_mem = (k % 2 == 0);
`else
                e_mem = 1'b1;
`endif
                chk1("arb_mem_gnt", bus.MemGnt, e_mem);
                chk1("arb_alu_gnt", bus.AluGnt, !e_mem);
            end
        end

        // Write to r0 is consumed without a register-file write and leaves busy bits alone
        do_reset();
        @(negedge Clk);
        bus.IssueVld = 1'b1;
        bus.IssueRD  = 5'd9;
        @(negedge Clk);
        bus.IssueVld = 1'b0;
        bus.AluReq   = 1'b1;
        bus.AluRD    = 5'd0;
        bus.AluData  = 32'hFFFF_FFFF;
        #2;
        chk1("r0_alu_gnt", bus.AluGnt, 1'b1);
        @(negedge Clk);
        bus.AluReq = 1'b0;
        bus.RS1    = 5'd9;
        bus.RS2    = 5'd1;
        #2;
        chk1("r0_regwr", bus.RegWr, 1'b0);
        chk1("r0_busy_kept", bus.Hazard, 1'b1);
        bus.RS1 = 5'd0;
        #1;
        chk1("r0_other_clear", bus.Hazard, 1'b0);

        // Set and clear of the same register collide, then a genuine double issue
        do_reset();
        @(negedge Clk);
        bus.IssueVld = 1'b1;
        bus.IssueRD  = 5'd7;
        @(negedge Clk);
        bus.IssueVld = 1'b0;
        bus.AluReq   = 1'b1;
        bus.AluRD    = 5'd7;
        bus.AluData  = 32'h0000_7777;
        #2;
        chk1("col_alu_gnt", bus.AluGnt, 1'b1);
        @(negedge Clk);
        bus.AluReq   = 1'b0;
        bus.IssueVld = 1'b1;
        bus.IssueRD  = 5'd7;
        #2;
        chk1 ("col_regwr", bus.RegWr, 1'b1);
        chk32("col_rd", 32'(bus.RD), 32'd7);
        @(negedge Clk);
        bus.RS1 = 5'd7;
        #2;
        chk1("col_busy_set", bus.Hazard, 1'b1);
        chk1("col_no_err", bus.BusyErr, 1'b0);
        @(negedge Clk);
        bus.IssueVld = 1'b0;
        #2;
        chk1("col_err_set", bus.BusyErr, 1'b1);
        repeat (3) @(negedge Clk);
        #2;
        chk1("col_err_sticky", bus.BusyErr, 1'b1);

        // Reset pulse while a captured writeback is waiting to commit
        do_reset();
        @(negedge Clk);
        bus.IssueVld = 1'b1;
        bus.IssueRD  = 5'd20;
        @(negedge Clk);
        bus.IssueVld = 1'b0;
        bus.MemReq   = 1'b1;
        bus.MemRD    = 5'd20;
        bus.MemData  = 32'hDEAD_BEEF;
        #2;
        chk1("rp_mem_gnt", bus.MemGnt, 1'b1);
        @(posedge Clk);
        #2;
        bus.MemReq = 1'b0;
        chk1("rp_captured", bus.RegWr, 1'b1);
        #1;
        Reset      = 1'b1;
        bus.RS1    = 5'd20;
        bus.RS2    = 5'd20;
        bus.AluReq = 1'b1;
        bus.MemReq = 1'b1;
        #1;
        chk1 ("rp_regwr_now", bus.RegWr, 1'b0);
        chk32("rp_rd_now", 32'(bus.RD), 32'h0);
        chk32("rp_wdata_now", bus.WData, 32'h0);
        chk1 ("rp_hazard", bus.Hazard, 1'b0);
        chk1 ("rp_alu_gnt", bus.AluGnt, 1'b0);
        chk1 ("rp_mem_gnt_rst", bus.MemGnt, 1'b0);
        @(negedge Clk);
        Reset      = 1'b0;
        bus.AluReq = 1'b0;
        bus.MemReq = 1'b0;
        #2;
        chk1("rp_hazard_after", bus.Hazard, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge Clk);
            #2;
            chk1("rp_no_write", bus.RegWr, 1'b0);
        end

        // Randomized traffic against the scoreboard model
        do_reset();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge Clk);
            if (!ap && $urandom_range(0, 2) != 0) begin
                ap   = 1'b1;
                ard  = 5'($urandom_range(0, 7));
                adat = $urandom;
            end
            if (!mp && $urandom_range(0, 2) != 0) begin
                mp   = 1'b1;
                mrd  = 5'($urandom_range(0, 7));
                mdat = $urandom;
            end
            iv  = ($urandom_range(0, 3) == 0);
            ird = 5'($urandom_range(0, 7));
            r1  = 5'($urandom_range(0, 7));
            r2  = 5'($urandom_range(0, 7));
            bus.AluReq   = ap;
            bus.AluRD    = ard;
            bus.AluData  = adat;
            bus.MemReq   = mp;
            bus.MemRD    = mrd;
            bus.MemData  = mdat;
            bus.IssueVld = iv;
            bus.IssueRD  = ird;
            bus.RS1      = r1;
            bus.RS2      = r2;
            #2;
            if (ap && mp) begin
`ifdef WB_RR_ARB_EN
                g_mem = !m_last_mem;
`else
                g_mem = 1'b1;
`endif
                g_alu = !g_mem;
            end else begin
                g_mem = mp;
                g_alu = ap;
            end
            e_haz = (r1 != 0 && m_busy[r1]) || (r2 != 0 && m_busy[r2]);
            chk1 ("rnd_alu_gnt", bus.AluGnt, g_alu);
            chk1 ("rnd_mem_gnt", bus.MemGnt, g_mem);
            chk1 ("rnd_hazard",  bus.Hazard, e_haz);
            chk1 ("rnd_regwr",   bus.RegWr, m_regwr);
            chk32("rnd_rd",      32'(bus.RD), 32'(m_rd));
            chk32("rnd_wdata",   bus.WData, m_wdata);
            chk1 ("rnd_busyerr", bus.BusyErr, m_err);

            // Advance the model through the coming clock edge
            clearing = m_regwr ? int'(m_rd) : -1;
            if (iv && ird != 0 && m_busy[ird] && int'(ird) != clearing) m_err = 1'b1;
            if (clearing > 0) m_busy[clearing] = 1'b0;
            if (iv && ird != 0) m_busy[ird] = 1'b1;
            if (g_mem || g_alu) begin
                nrd        = g_mem ? mrd : ard;
                ndat       = g_mem ? mdat : adat;
                m_regwr    = (nrd != 0);
                m_rd       = nrd;
                m_wdata    = ndat;
                m_last_mem = g_mem;
                if (g_mem) mp = 1'b0;
                else       ap = 1'b0;
            end else begin
                m_regwr = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
